// File: rtl/rvfi_commit_serializer.sv
// rvfi_commit_serializer: buffers up to NUM_CH retirements per cycle and replays them one per cycle to RVFI
//   clk, rst             clock, synchronous active-high reset
//   in_valid, in_pkt     per-channel commit valid and packet (channel 0 oldest)
//   in_ready             buffer can absorb NUM_CH packets this cycle
//   out_commit, out_pkt  one packet per cycle towards the monitor
//   out_order            rvfi order of out_pkt
//   halt, err_ovf        sticky self-loop and protocol error flags
//   occupancy            entries currently buffered
module rvfi_commit_serializer #(
    parameter int NUM_CH  = 2,
    parameter int DEPTH   = 8,
    parameter int PKT_W   = 312,
    parameter int ORDER_W = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           in_valid,
    input  logic [NUM_CH*PKT_W-1:0]     in_pkt,
    output logic                        in_ready,
    output logic                        out_commit,
    output logic [PKT_W-1:0]            out_pkt,
    output logic [ORDER_W-1:0]          out_order,
    output logic                        halt,
    output logic                        err_ovf,
    output logic [$clog2(DEPTH):0]      occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PKT_W-1:0]   mem_q [DEPTH];
    logic [AW-1:0]      wp_q, rp_q;
    logic [CW-1:0]      occ_q, occ_d, n_in;
    logic [ORDER_W-1:0] cnt_q, out_order_q;
    logic [PKT_W-1:0]   out_pkt_q, head;
    logic               in_ready_q, out_commit_q, halt_q, err_q;
    logic               contig, acc, pop, hit;

    // An empty buffer bypasses channel 0 straight to the output register,
    // giving one-cycle latency while pointers advance as if it had been stored.
    always_comb begin
        n_in = '0;
        for (int i = 0; i < NUM_CH; i++) n_in = n_in + CW'(in_valid[i]);
        contig = (in_valid & (in_valid + NUM_CH'(1))) == '0;
        acc    = in_ready_q && contig && |in_valid;
        head   = (occ_q != '0) ? mem_q[rp_q] : in_pkt[PKT_W-1:0];
        pop    = !halt_q && (occ_q != '0 || acc);
        occ_d  = occ_q + (acc ? n_in : '0) - CW'(pop);
        hit    = head[151:120] == head[119:88];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++)
            if (acc && in_valid[i]) mem_q[wp_q + AW'(i)] <= in_pkt[i*PKT_W +: PKT_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q         <= '0;
            rp_q         <= '0;
            occ_q        <= '0;
            cnt_q        <= '0;
            in_ready_q   <= 1'b1;
            out_commit_q <= 1'b0;
            out_pkt_q    <= '0;
            out_order_q  <= '0;
            halt_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            wp_q         <= wp_q + (acc ? AW'(n_in) : '0);
            rp_q         <= rp_q + AW'(pop);
            occ_q        <= occ_d;
            in_ready_q   <= (CW'(DEPTH) - occ_d) >= CW'(NUM_CH);
            out_commit_q <= pop;
            if (pop) begin
                out_pkt_q   <= head;
                out_order_q <= cnt_q;
                cnt_q       <= cnt_q + 1'b1;
            end
            halt_q <= halt_q | (pop & hit);
            err_q  <= err_q | (|in_valid && !(in_ready_q && contig));
        end
    end

    assign in_ready   = in_ready_q;
    assign out_commit = out_commit_q;
    assign out_pkt    = out_pkt_q;
    assign out_order  = out_order_q;
    assign halt       = halt_q;
    assign err_ovf    = err_q;
    assign occupancy  = occ_q;
endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// tb_rvfi_commit_serializer: directed bench with a pc scoreboard for rvfi_commit_serializer
module tb_rvfi_commit_serializer;
    localparam int PKT_W = 312;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     in_valid;
    logic [2*PKT_W-1:0] in_pkt;
    logic           in_ready, out_commit, halt, err_ovf;
    logic [PKT_W-1:0] out_pkt;
    logic [63:0]    out_order;
    logic [3:0]     occupancy;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q [$];
    logic [63:0] ord;
    logic        seen;
    logic [3:0]  occ_b;

    rvfi_commit_serializer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pkt(in_pkt),
        .in_ready(in_ready), .out_commit(out_commit), .out_pkt(out_pkt),
        .out_order(out_order), .halt(halt), .err_ovf(err_ovf), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PKT_W-1:0] mk(input logic [31:0] pcr, input logic h);
        logic [PKT_W-1:0] r;
        r = {39{8'hA5}};
        r[151:120] = pcr;
        r[119:88]  = h ? pcr : pcr + 32'd4;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_commit) begin
            if (exp_q.size() == 0) chk("spurious", 1, 0);
            else begin
                chk("pc", {32'd0, out_pkt[151:120]}, {32'd0, exp_q.pop_front()});
                chk("order", out_order, ord);
                ord = ord + 1;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        in_pkt = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        ord = '0;
    endtask

    task automatic beat(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1, input logic h0);
        logic ok;
        ok = in_ready && (v == 2'b01 || v == 2'b11);
        in_valid = v;
        in_pkt = {mk(p1, 1'b0), mk(p0, h0)};
        if (ok) begin
            exp_q.push_back(p0);
            if (v[1]) exp_q.push_back(p1);
        end
        @(posedge clk);
        #1;
        in_valid = '0;
    endtask

    task automatic idle(input int n);
        in_valid = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((occupancy != 0 || exp_q.size() != 0) && k < 40) begin
            idle(1);
            k++;
        end
        chk("drain", {63'd0, k < 40}, 1);
    endtask

    initial begin
        do_reset();
        chk("rst_commit", {63'd0, out_commit}, 0);
        chk("rst_ready", {63'd0, in_ready}, 1);
        chk("rst_occ", {60'd0, occupancy}, 0);
        chk("rst_halt", {63'd0, halt}, 0);
        chk("rst_err", {63'd0, err_ovf}, 0);

        beat(2'b01, 32'h60, 32'h0, 1'b0);
        chk("single_commit", {63'd0, out_commit}, 1);
        chk("single_order", out_order, 0);
        idle(1);

        do_reset();
        beat(2'b11, 32'h60, 32'h64, 1'b0);
        chk("dual_c0", {63'd0, out_commit}, 1);
        idle(1);
        chk("dual_c1", {63'd0, out_commit}, 1);
        chk("dual_o1", out_order, 1);
        idle(1);
        chk("dual_idle", {63'd0, out_commit}, 0);

        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("bp_ready", {63'd0, in_ready}, {63'd0, occupancy <= 4'd6});
            if (!in_ready) seen = 1'b1;
            if (in_ready) beat(2'b11, 32'h1000 + 32'(8*i), 32'h1004 + 32'(8*i), 1'b0);
            else idle(1);
        end
        chk("bp_seen", {63'd0, seen}, 1);
        drain();
        chk("bp_err", {63'd0, err_ovf}, 0);

        for (int i = 0; i < 10 && in_ready; i++) beat(2'b11, 32'h2000 + 32'(8*i), 32'h2004 + 32'(8*i), 1'b0);
        chk("ovf_full", {63'd0, in_ready}, 0);
        occ_b = occupancy;
        beat(2'b11, 32'hDEAD0, 32'hDEAD4, 1'b0);
        chk("ovf_err", {63'd0, err_ovf}, 1);
        chk("ovf_occ", {60'd0, occupancy}, {60'd0, occ_b - 4'd1});
        drain();
        chk("ovf_sticky", {63'd0, err_ovf}, 1);

        do_reset();
        beat(2'b10, 32'h3000, 32'h3004, 1'b0);
        chk("gap_err", {63'd0, err_ovf}, 1);
        chk("gap_commit", {63'd0, out_commit}, 0);
        chk("gap_occ", {60'd0, occupancy}, 0);

        do_reset();
        beat(2'b01, 32'h80, 32'h0, 1'b1);
        chk("halt_set", {63'd0, halt}, 1);
        chk("halt_commit", {63'd0, out_commit}, 1);
        beat(2'b11, 32'h84, 32'h88, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("halt_nocommit", {63'd0, out_commit}, 0);
            idle(1);
        end
        chk("halt_occ", {60'd0, occupancy}, 2);
        chk("halt_sticky", {63'd0, halt}, 1);

        beat(2'b11, 32'h8C, 32'h90, 1'b0);
        beat(2'b01, 32'h94, 32'h0, 1'b0);
        chk("mid_occ5", {60'd0, occupancy}, 5);
        do_reset();
        chk("mid_occ0", {60'd0, occupancy}, 0);
        chk("mid_halt", {63'd0, halt}, 0);
        beat(2'b01, 32'hA0, 32'h0, 1'b0);
        chk("mid_commit", {63'd0, out_commit}, 1);
        chk("mid_order", out_order, 0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
